gauss_filter_7x7: RTL and testbench

GAUSS_FILTER_7X7 -- requirements
Module: gauss_filter_7x7

---
 rtl/gauss_filter_7x7_pkg.sv | 46 ++++
 rtl/gauss_filter_7x7_if.sv | 22 ++
 rtl/gauss_filter_7x7_binom7_mac.sv | 32 +++
 rtl/gauss_filter_7x7.sv | 129 ++++++++++++
 tb/tb_gauss_filter_7x7.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gauss_filter_7x7_pkg.sv
// Shared constants, sideband payload and shift-add helpers for the 7x7 binomial window filters.
package gauss_filter_7x7_pkg;

    localparam int unsigned TAPS   = 7;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned WIN_W  = TAPS * TAPS * PIX_W;
    localparam int unsigned V_W    = 14;
    localparam int unsigned H_W    = 20;
    localparam int unsigned ROUND  = 2048;
    localparam int unsigned SHIFT  = 12;
    localparam int unsigned MARGIN = 3;
    localparam int unsigned CENTRE = (TAPS * TAPS) / 2;

    // Data that travels alongside the arithmetic pipeline
    typedef struct packed {
        logic             border;
        logic             last;
        logic [PIX_W-1:0] centre;
    } side_t;

    // Binomial kernel [1,6,15,20,15,6,1]; 64 per axis, 4096 for the 2-D kernel
    function automatic int unsigned kcoef(input int unsigned i);
        int unsigned k;
        case (i)
            0, 6:    k = 1;
            1, 5:    k = 6;
            2, 4:    k = 15;
            default: k = 20;
        endcase
        return k;
    endfunction

    // Coefficient multiply as shifts and adds; k is constant per call site
    function automatic logic [H_W-1:0] kmul(input logic [H_W-1:0] x, input int unsigned k);
        logic [H_W-1:0] p;
        case (k)
            1:       p = x;
            6:       p = (x << 2) + (x << 1);
            15:      p = (x << 4) - x;
            20:      p = (x << 4) + (x << 2);
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/gauss_filter_7x7_if.sv
// Window-in / filtered-pixel-out bundle between the line buffer side and the filter.
interface gauss_filter_7x7_if;
    import gauss_filter_7x7_pkg::*;

    logic [WIN_W-1:0] win;
    logic             win_valid;
    logic [PIX_W-1:0] dout;
    logic             dout_valid;
    logic             dout_border;
    logic             frame_done;

    modport master (
        output win, win_valid,
        input  dout, dout_valid, dout_border, frame_done
    );

    modport slave (
        input  win, win_valid,
        output dout, dout_valid, dout_border, frame_done
    );

endinterface

// File: rtl/gauss_filter_7x7_binom7_mac.sv
// Registered 7-tap binomial weighted sum; used for both the column and row passes.
module binom7_mac
    import gauss_filter_7x7_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TAPS*IN_W-1:0] taps,
    output logic [OUT_W-1:0]     sum
);

    logic [OUT_W-1:0] acc;

    // OUT_W is sized for the all-max input, so partial sums never wrap
    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < TAPS; i++) begin
            acc = acc + OUT_W'(kmul(H_W'(taps[i*IN_W +: IN_W]), kcoef(i)));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else begin
            sum <= acc;
        end
    end

endmodule

// File: rtl/gauss_filter_7x7.sv
// 7x7 separable binomial smoothing filter, 3-cycle latency, border pixels passed through.
module gauss_filter_7x7
    import gauss_filter_7x7_pkg::*;
#(
    parameter int unsigned IMG_W = 512,
    parameter int unsigned IMG_H = 512
) (
    input  logic               clk,
    input  logic               rst,
    gauss_filter_7x7_if.slave  bus
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned COL_TAPS_W = TAPS * PIX_W;

    logic [TAPS*COL_TAPS_W-1:0] col_flat;
    logic [TAPS*V_W-1:0]        h_taps;
    logic [H_W-1:0]             h_sum;
    logic [PIX_W-1:0]           filt;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             col_last;
    logic             row_last;
    logic             border_c;
    side_t            side_c;
    side_t            side_s1;
    side_t            side_s2;
    logic             vld_s1;
    logic             vld_s2;

    logic [PIX_W-1:0] dout_q;
    logic             dout_valid_q;
    logic             dout_border_q;
    logic             frame_done_q;

    // Stage 1: one vertical MAC per window column, stage 2: one horizontal MAC
    for (genvar c = 0; c < TAPS; c++) begin : g_col
        logic [V_W-1:0] v_sum;

        for (genvar r = 0; r < TAPS; r++) begin : g_row
            assign col_flat[c*COL_TAPS_W + r*PIX_W +: PIX_W] = bus.win[(r*TAPS + c)*PIX_W +: PIX_W];
        end

        binom7_mac #(
            .IN_W  (PIX_W),
            .OUT_W (V_W)
        ) u_vmac (
            .clk  (clk),
            .rst  (rst),
            .taps (col_flat[c*COL_TAPS_W +: COL_TAPS_W]),
            .sum  (v_sum)
        );

        assign h_taps[c*V_W +: V_W] = v_sum;
    end

    binom7_mac #(
        .IN_W  (V_W),
        .OUT_W (H_W)
    ) u_hmac (
        .clk  (clk),
        .rst  (rst),
        .taps (h_taps),
        .sum  (h_sum)
    );

    // H + 2048 stays below 2^20, so the rounded quotient always fits in 8 bits
    assign filt = PIX_W'((h_sum + H_W'(ROUND)) >> SHIFT);

    assign col_last = (col == COL_W'(IMG_W - 1));
    assign row_last = (row == ROW_W'(IMG_H - 1));
    assign border_c = (col < COL_W'(MARGIN)) || (col > COL_W'(IMG_W - 1 - MARGIN)) ||
                      (row < ROW_W'(MARGIN)) || (row > ROW_W'(IMG_H - 1 - MARGIN));

    always_comb begin
        side_c        = '0;
        side_c.border = border_c;
        side_c.last   = bus.win_valid & col_last & row_last;
        side_c.centre = bus.win[CENTRE*PIX_W +: PIX_W];
    end

    // Window-centre position; advances only on accepted windows
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.win_valid) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Sideband and valid track the MACs; output stage holds across bubbles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            side_s1       <= '0;
            side_s2       <= '0;
            vld_s1        <= 1'b0;
            vld_s2        <= 1'b0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            dout_border_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            side_s1      <= side_c;
            side_s2      <= side_s1;
            vld_s1       <= bus.win_valid;
            vld_s2       <= vld_s1;
            dout_valid_q <= vld_s2;
            frame_done_q <= vld_s2 & side_s2.last;
            if (vld_s2) begin
                dout_q        <= side_s2.border ? side_s2.centre : filt;
                dout_border_q <= side_s2.border;
            end
        end
    end

    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.dout_border = dout_border_q;
    assign bus.frame_done  = frame_done_q;

endmodule

// File: tb/tb_gauss_filter_7x7.sv
// Directed bench for gauss_filter_7x7 on a reduced 16x12 frame with a latency-tagged scoreboard.
module tb_gauss_filter_7x7;
    import gauss_filter_7x7_pkg::*;

    localparam int TW   = 16;
    localparam int TH   = 12;
    localparam int NPIX = TW * TH;
    localparam int NT   = 18;

    logic clk = 1'b0;
    logic rst;

    gauss_filter_7x7_if bus ();

    gauss_filter_7x7 #(
        .IMG_W (TW),
        .IMG_H (TH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               idx;
        logic [WIN_W-1:0] w;
        logic [7:0]       dout;
        logic             border;
    } vec_t;

    typedef struct {
        logic [7:0] dout;
        logic       border;
        logic       last;
        int         cyc;
    } exp_t;

    vec_t       tbl [NT];
    exp_t       sb [$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         valid_cnt = 0;
    int         fd_cnt = 0;
    int         ti = 0;
    logic [7:0] last_out = '0;
    bit         have_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIN_W-1:0] w_fill(input logic [7:0] v);
        logic [WIN_W-1:0] w;
        for (int i = 0; i < TAPS * TAPS; i++) w[i*8 +: 8] = v;
        return w;
    endfunction

    function automatic logic [WIN_W-1:0] w_set(input logic [WIN_W-1:0] w0, input int r, input int c,
                                               input logic [7:0] v);
        logic [WIN_W-1:0] w;
        w = w0;
        w[(r*TAPS + c)*8 +: 8] = v;
        return w;
    endfunction

    function automatic vec_t mkv(input int idx, input logic [WIN_W-1:0] w, input logic [7:0] d,
                                 input logic b);
        vec_t v;
        v.idx = idx; v.w = w; v.dout = d; v.border = b;
        return v;
    endfunction

    function automatic logic border_of(input int idx);
        int r, c;
        r = idx / TW;
        c = idx % TW;
        return (c < 3) || (c > TW - 4) || (r < 3) || (r > TH - 4);
    endfunction

    task automatic send(input logic [WIN_W-1:0] w, input logic [7:0] d, input logic b, input logic l);
        exp_t e;
        @(posedge clk);
        #1;
        bus.win       = w;
        bus.win_valid = 1'b1;
        e.dout = d; e.border = b; e.last = l; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.win       = w_fill(8'($urandom));
        bus.win_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
        chk("drain_pending", sb.size(), 0);
    endtask

    // Table entries override the constant filler at their frame position
    task automatic stream(input int from, input int to, input bit use_tbl);
        logic [7:0] v;
        for (int idx = from; idx <= to; idx++) begin
            if ($urandom_range(0, 3) == 0) idle();
            if (use_tbl && ti < NT && tbl[ti].idx == idx) begin
                send(tbl[ti].w, tbl[ti].dout, tbl[ti].border, idx == NPIX - 1);
                ti++;
            end else begin
                v = 8'(idx * 7 + 3);
                send(w_fill(v), v, border_of(idx), idx == NPIX - 1);
            end
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_dout"}, int'(bus.dout), 0);
        chk({tag, "_dout_valid"}, int'(bus.dout_valid), 0);
        chk({tag, "_dout_border"}, int'(bus.dout_border), 0);
        chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
    endtask

    // Scoreboard: every valid output matches the oldest pending window, 3 cycles later
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            sb.delete();
            have_prev = 0;
        end else if (bus.dout_valid) begin
            valid_cnt++;
            if (bus.frame_done) fd_cnt++;
            chk("output_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("dout", int'(bus.dout), int'(e.dout));
                chk("dout_border", int'(bus.dout_border), int'(e.border));
                chk("frame_done", int'(bus.frame_done), int'(e.last));
                chk("latency", cyc - e.cyc, 3);
            end
            last_out  = bus.dout;
            have_prev = 1;
        end else begin
            chk("frame_done_idle", int'(bus.frame_done), 0);
            if (have_prev) chk("dout_hold", int'(bus.dout), int'(last_out));
        end
    end

    initial begin
        logic [WIN_W-1:0] w_imp, w_255, w_hole, w_corner, w_colimp, w_hline, w_grad;

        rst           = 1'b0;
        bus.win       = '0;
        bus.win_valid = 1'b0;

        w_imp    = w_set(w_fill(8'd0), 3, 3, 8'd255);
        w_255    = w_fill(8'd255);
        w_hole   = w_set(w_255, 3, 3, 8'd9);
        w_corner = w_set(w_fill(8'd0), 0, 0, 8'd255);
        w_colimp = w_set(w_fill(8'd0), 3, 0, 8'd255);
        w_hline  = w_fill(8'd0);
        w_grad   = w_fill(8'd0);
        for (int c = 0; c < TAPS; c++) begin
            w_hline = w_set(w_hline, 3, c, 8'd200);
            for (int r = 0; r < TAPS; r++) w_grad = w_set(w_grad, r, c, 8'(10 * c));
        end

        // idx = row*16 + col; border: col<3, col>12, row<3, row>8
        tbl[0]  = mkv(0,   w_imp,            8'd255, 1'b1);
        tbl[1]  = mkv(1,   w_fill(8'd100),   8'd100, 1'b1);
        tbl[2]  = mkv(2,   w_hole,           8'd9,   1'b1);
        tbl[3]  = mkv(18,  w_imp,            8'd255, 1'b1);
        tbl[4]  = mkv(51,  w_fill(8'd100),   8'd100, 1'b0);
        tbl[5]  = mkv(52,  w_imp,            8'd25,  1'b0);
        tbl[6]  = mkv(53,  w_255,            8'd255, 1'b0);
        tbl[7]  = mkv(60,  w_imp,            8'd25,  1'b0);
        tbl[8]  = mkv(61,  w_imp,            8'd255, 1'b1);
        tbl[9]  = mkv(64,  w_imp,            8'd255, 1'b1);
        tbl[10] = mkv(66,  w_imp,            8'd255, 1'b1);
        tbl[11] = mkv(67,  w_hline,          8'd63,  1'b0);
        tbl[12] = mkv(70,  w_corner,         8'd0,   1'b0);
        tbl[13] = mkv(71,  w_colimp,         8'd1,   1'b0);
        tbl[14] = mkv(72,  w_grad,           8'd30,  1'b0);
        tbl[15] = mkv(140, w_imp,            8'd25,  1'b0);
        tbl[16] = mkv(149, w_imp,            8'd255, 1'b1);
        tbl[17] = mkv(191, w_fill(8'd100),   8'd100, 1'b1);

        @(negedge clk);
        chk_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // One full frame with random bubbles
        stream(0, NPIX - 1, 1);
        drain();
        chk("frame_valid_count", valid_cnt, NPIX);
        chk("frame_done_count", fd_cnt, 1);

        // Counters wrapped: next window is (0,0) again
        send(w_imp, 8'd255, 1'b1, 1'b0);
        stream(1, 85, 0);

        // Mid-frame reset with windows still in flight
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.win_valid = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int k = 0; k < 3; k++) begin
            send(w_fill(8'(k * 7 + 3)), 8'(k * 7 + 3), 1'b1, 1'b0);
            @(negedge clk);
            chk("no_valid_after_release", int'(bus.dout_valid), 0);
        end
        stream(3, 6, 0);
        send(w_imp, 8'd255, 1'b1, 1'b0);
        stream(8, 50, 0);
        send(w_imp, 8'd25, 1'b0, 1'b0);
        drain();
        chk("frame_done_total", fd_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
